// File: rtl/fft32_stage_ctrl.sv
// Issue/writeback sequencer for the iterative 32-point radix-2 DIT FFT:
// 5 stages x 4 groups of 4 butterflies, with per-lane addresses, twiddles and an L-deep writeback line.
module fft32_stage_ctrl #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned BF_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [2:0]  stage,
    output logic        rd_en,
    output logic [1:0]  rd_grp,
    output logic [19:0] rd_addr_top,
    output logic [19:0] rd_addr_bot,
    output logic [15:0] tw_exp,
    output logic        wr_en,
    output logic [19:0] wr_addr_top,
    output logic [19:0] wr_addr_bot
);

    localparam int unsigned L         = MEM_LAT + BF_LAT;
    localparam int unsigned LANES     = 4;
    localparam int unsigned AW        = 5;
    localparam int unsigned TW        = 4;
    localparam logic [2:0]  LAST_STG  = 3'd4;
    localparam logic [1:0]  LAST_GRP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t     state;
    logic [2:0] stg;
    logic [1:0] grp;

    logic        dly_vld  [L];
    logic        dly_last [L];
    logic [19:0] dly_top  [L];
    logic [19:0] dly_bot  [L];

    logic wb_last;

    // Top input address of butterfly b at stage s.
    function automatic logic [4:0] top_addr(input logic [4:0] b, input logic [2:0] s);
        logic [4:0] h;
        logic [4:0] j;
        h = 5'(1) << s;
        j = b & 5'(h - 5'd1);
        return 5'(((b >> s) << (s + 3'd1)) + j);
    endfunction

    function automatic logic [4:0] bot_addr(input logic [4:0] b, input logic [2:0] s);
        return 5'(top_addr(b, s) + (5'(1) << s));
    endfunction

    // Twiddle exponent: (b mod 2^s) scaled to the W32 root.
    function automatic logic [3:0] tw_of(input logic [4:0] b, input logic [2:0] s);
        logic [4:0] j;
        j = b & 5'((5'(1) << s) - 5'd1);
        return 4'(j << (3'd4 - s));
    endfunction

    // Control state; DONE also samples start so a held start restarts without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            stg   <= '0;
            grp   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ISSUE;
                        stg   <= '0;
                        grp   <= '0;
                    end
                end
                ST_ISSUE: begin
                    grp <= 2'(grp + 2'd1);
                    if (grp == LAST_GRP) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wb_last) begin
                        if (stg == LAST_STG) begin
                            state <= ST_DONE;
                        end else begin
                            stg   <= 3'(stg + 3'd1);
                            grp   <= '0;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    stg <= '0;
                    grp <= '0;
                    if (start) begin
                        state <= ST_ISSUE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE);
    assign rd_en  = (state == ST_ISSUE);
    assign stage  = stg;
    assign rd_grp = rd_en ? grp : 2'd0;

    // Per-lane address and twiddle generation from the registered stage/group.
    always_comb begin
        rd_addr_top = '0;
        rd_addr_bot = '0;
        tw_exp      = '0;
        if (rd_en) begin
            for (int n = 0; n < LANES; n++) begin
                rd_addr_top[n*AW +: AW] = top_addr({1'b0, grp, 2'(n)}, stg);
                rd_addr_bot[n*AW +: AW] = bot_addr({1'b0, grp, 2'(n)}, stg);
                tw_exp[n*TW +: TW]      = tw_of({1'b0, grp, 2'(n)}, stg);
            end
        end
    end

    // Writeback delay line; addresses are already zero when rd_en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                dly_vld[i]  <= 1'b0;
                dly_last[i] <= 1'b0;
                dly_top[i]  <= '0;
                dly_bot[i]  <= '0;
            end
        end else begin
            for (int i = L - 1; i > 0; i--) begin
                dly_vld[i]  <= dly_vld[i-1];
                dly_last[i] <= dly_last[i-1];
                dly_top[i]  <= dly_top[i-1];
                dly_bot[i]  <= dly_bot[i-1];
            end
            dly_vld[0]  <= rd_en;
            dly_last[0] <= rd_en && (grp == LAST_GRP);
            dly_top[0]  <= rd_addr_top;
            dly_bot[0]  <= rd_addr_bot;
        end
    end

    assign wb_last     = dly_last[L-1];
    assign wr_en       = dly_vld[L-1];
    assign wr_addr_top = dly_top[L-1];
    assign wr_addr_bot = dly_bot[L-1];

endmodule

// File: tb/tb_fft32_stage_ctrl.sv
// Directed bench for fft32_stage_ctrl: default L=2 instance and an L=5 instance,
// cycle-accurate strobe checks, hand-computed address vectors and a read/writeback scoreboard.
module tb_fft32_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, start_a, start_b, sel;

    logic        a_busy, a_done, a_rd_en, a_wr_en, b_busy, b_done, b_rd_en, b_wr_en;
    logic [2:0]  a_stage, b_stage;
    logic [1:0]  a_rd_grp, b_rd_grp;
    logic [19:0] a_rt, a_rb, a_wt, a_wb, b_rt, b_rb, b_wt, b_wb;
    logic [15:0] a_tw, b_tw;

    fft32_stage_ctrl u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .busy(a_busy), .done(a_done),
        .stage(a_stage), .rd_en(a_rd_en), .rd_grp(a_rd_grp), .rd_addr_top(a_rt),
        .rd_addr_bot(a_rb), .tw_exp(a_tw), .wr_en(a_wr_en), .wr_addr_top(a_wt),
        .wr_addr_bot(a_wb)
    );

    fft32_stage_ctrl #(.MEM_LAT(3), .BF_LAT(2)) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .busy(b_busy), .done(b_done),
        .stage(b_stage), .rd_en(b_rd_en), .rd_grp(b_rd_grp), .rd_addr_top(b_rt),
        .rd_addr_bot(b_rb), .tw_exp(b_tw), .wr_en(b_wr_en), .wr_addr_top(b_wt),
        .wr_addr_bot(b_wb)
    );

    logic        o_busy, o_done, o_rd_en, o_wr_en;
    logic [2:0]  o_stage;
    logic [1:0]  o_rd_grp;
    logic [19:0] o_rt, o_rb, o_wt, o_wb;
    logic [15:0] o_tw;
    wire  [104:0] a_all = {a_busy, a_done, a_stage, a_rd_en, a_rd_grp, a_rt, a_rb, a_tw, a_wr_en, a_wt, a_wb};
    wire  [104:0] b_all = {b_busy, b_done, b_stage, b_rd_en, b_rd_grp, b_rt, b_rb, b_tw, b_wr_en, b_wt, b_wb};
    assign {o_busy, o_done, o_stage, o_rd_en, o_rd_grp, o_rt, o_rb, o_tw, o_wr_en, o_wt, o_wb} = sel ? b_all : a_all;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_rd(input int c, input int lat);
        int s, off;
        if (c < 1) return 1'b0;
        s   = (c - 1) / (4 + lat);
        off = (c - 1) % (4 + lat);
        return (s < 5) && (off < 4);
    endfunction

    task automatic set_start(input bit v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic set_rst(input bit v);
        if (sel) rst_b = v; else rst_a = v;
    endtask

    // One transform from a start pulse in the current cycle (cycle 0).
    task automatic run_tx(input bit use_b, input int lat, input bit hold, input int rst_at, input bit pulse10);
        int rd_cnt [5][32];
        logic [19:0] hist_t [64];
        logic [19:0] hist_b [64];
        int n_last, c_done, s, off, bad;
        bit er, ew, eb, ed;
        sel = use_b;
        for (int i = 0; i < 5; i++) for (int a = 0; a < 32; a++) rd_cnt[i][a] = 0;
        for (int i = 0; i < 64; i++) begin hist_t[i] = '0; hist_b[i] = '0; end
        c_done = 21 + 5 * lat;
        n_last = hold ? c_done + 1 : (rst_at > 0 ? rst_at : c_done + 2);
        set_start(1'b1);
        for (int c = 1; c <= n_last; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) set_start(1'b0);
            er = exp_rd(c, lat);
            ew = exp_rd(c - lat, lat);
            ed = (c == c_done);
            eb = (c <= c_done);
            if (hold && c == c_done + 1) begin er = 1'b1; eb = 1'b1; end
            chk($sformatf("ctl c%0d", c), {o_busy, o_done, o_rd_en, o_wr_en}, {eb, ed, er, ew});
            s   = (c - 1) / (4 + lat);
            off = (c - 1) % (4 + lat);
            if (o_rd_en && er && s < 5) begin
                chk($sformatf("stg_grp c%0d", c), {o_stage, o_rd_grp}, {3'(s), 2'(off)});
                for (int n = 0; n < 4; n++) begin
                    rd_cnt[s][o_rt[n*5 +: 5]]++;
                    rd_cnt[s][o_rb[n*5 +: 5]]++;
                end
                hist_t[c] = o_rt;
                hist_b[c] = o_rb;
            end
            if (o_wr_en && c > lat)
                chk($sformatf("wb_addr c%0d", c), {o_wt, o_wb}, {hist_t[c-lat], hist_b[c-lat]});
            if (!o_rd_en && !o_wr_en)
                chk($sformatf("idle_addr c%0d", c), {o_rt, o_rb, o_tw, o_wt, o_wb}, '0);
            if (rst_at == 0 && !hold) begin
                if (c == 1)
                    chk("s0g0", {o_rt, o_rb, o_tw},
                        {5'd6, 5'd4, 5'd2, 5'd0, 5'd7, 5'd5, 5'd3, 5'd1, 16'h0000});
                if (c == 1 + 2 * (4 + lat) + 2)
                    chk("s2g2", {o_rt, o_rb, o_tw},
                        {5'd19, 5'd18, 5'd17, 5'd16, 5'd23, 5'd22, 5'd21, 5'd20, 16'hC840});
                if (c == 1 + 4 * (4 + lat) + 1)
                    chk("s4g1", {o_rt, o_rb, o_tw},
                        {5'd7, 5'd6, 5'd5, 5'd4, 5'd23, 5'd22, 5'd21, 5'd20, 16'h7654});
            end
            if (pulse10 && c == 10) set_start(1'b1);
            if (pulse10 && c == 11) set_start(1'b0);
            if (c == rst_at) set_rst(1'b1);
        end
        if (rst_at == 0 && !hold) begin
            for (int i = 0; i < 5; i++) begin
                bad = 0;
                for (int a = 0; a < 32; a++) if (rd_cnt[i][a] != 1) bad++;
                chk($sformatf("cover stage%0d", i), 128'(bad), 128'(0));
            end
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            sel = 1'b0; #1 chk($sformatf("reset_idle_a %0d", k), 128'(a_all), '0);
            sel = 1'b1; #1 chk($sformatf("reset_idle_b %0d", k), 128'(b_all), '0);
        end
        sel = 1'b0;

        run_tx(1'b0, 2, 1'b0, 0, 1'b1);

        run_tx(1'b0, 2, 1'b1, 0, 1'b0);
        start_a = 1'b0;
        repeat (40) @(negedge clk);

        run_tx(1'b0, 2, 1'b0, 12, 1'b0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("after_rst %0d", k), 128'(a_all), '0);
            if (k == 0) rst_a = 1'b0;
        end

        run_tx(1'b0, 2, 1'b0, 0, 1'b0);

        run_tx(1'b1, 5, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
